// File: rtl/recip_engine.sv
// recip_engine: fetches a 16-bit divisor from byte memory, computes the
// fixed-point reciprocal floor(2^15/d) (optionally half-LSB rounded) with a
// 17-step restoring divider, writes the 16-bit result back and raises Ack.
//
// state | meaning
// IDLE  | waiting for Start after reset
// RD_HI | reading divisor MSB
// RD_LO | reading divisor LSB, choose divide or zero-divisor shortcut
// DIV   | 17 restoring-divide iterations, one quotient bit per cycle
// WR_HI | writing result MSB
// WR_LO | writing result LSB
// DONE  | Ack held until next Start
module recip_engine #(
  parameter int DIVISOR_ADDR = 8,
  parameter int RESULT_ADDR  = 10,
  parameter int ROUND        = 0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Ack,
  output logic [7:0] MemAddr,
  input  logic [7:0] MemRdData,
  output logic [7:0] MemWrData,
  output logic       MemWrEn
);

  localparam logic [7:0] DIV_HI_A = 8'(DIVISOR_ADDR);
  localparam logic [7:0] DIV_LO_A = 8'(DIVISOR_ADDR + 1);
  localparam logic [7:0] RES_HI_A = 8'(RESULT_ADDR);
  localparam logic [7:0] RES_LO_A = 8'(RESULT_ADDR + 1);

  typedef enum logic [2:0] {IDLE, RD_HI, RD_LO, DIV, WR_HI, WR_LO, DONE} state_t;

  state_t      state, state_nx;
  logic [15:0] divisor;
  logic [16:0] quot;
  logic [16:0] rem;
  logic [4:0]  cnt;
  logic [17:0] rem_sh;
  logic        rem_ge;
  logic [15:0] result;

  // The dividend 2^16 is a single 1 followed by zeros, so its bit only
  // enters on the first iteration (counter still at its load value).
  assign rem_sh = {rem, (cnt == 5'd16)};
  assign rem_ge = (rem_sh >= {2'b00, divisor});

  // Result selection; q[16:1] <= 2^15 so the rounding add cannot overflow.
  always_comb begin
    result = quot[16:1];
    if (divisor == 16'h0000)
      result = 16'hFFFF;
    else if (ROUND != 0)
      result = quot[16:1] + {15'b0, quot[0]};
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next-state and memory-port outputs, decoded from state alone.
  always_comb begin
    state_nx  = state;
    Ack       = 1'b0;
    MemAddr   = 8'h00;
    MemWrData = 8'h00;
    MemWrEn   = 1'b0;
    case (state)
      IDLE: if (Start) state_nx = RD_HI;
      RD_HI: begin
        MemAddr  = DIV_HI_A;
        state_nx = RD_LO;
      end
      RD_LO: begin
        MemAddr  = DIV_LO_A;
        state_nx = ({divisor[15:8], MemRdData} != 16'h0000) ? DIV : WR_HI;
      end
      DIV: if (cnt == 5'd0) state_nx = WR_HI;
      WR_HI: begin
        MemAddr   = RES_HI_A;
        MemWrData = result[15:8];
        MemWrEn   = 1'b1;
        state_nx  = WR_LO;
      end
      WR_LO: begin
        MemAddr   = RES_LO_A;
        MemWrData = result[7:0];
        MemWrEn   = 1'b1;
        state_nx  = DONE;
      end
      DONE: begin
        Ack = 1'b1;
        if (Start) state_nx = RD_HI;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Divisor capture and restoring-divide datapath with down-counting iteration count.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      divisor <= 16'h0000;
      quot    <= 17'h00000;
      rem     <= 17'h00000;
      cnt     <= 5'd0;
    end else begin
      case (state)
        RD_HI: divisor[15:8] <= MemRdData;
        RD_LO: begin
          divisor[7:0] <= MemRdData;
          quot         <= 17'h00000;
          rem          <= 17'h00000;
          cnt          <= 5'd16;
        end
        DIV: begin
          quot <= {quot[15:0], rem_ge};
          rem  <= 17'(rem_ge ? (rem_sh - {2'b00, divisor}) : rem_sh);
          if (cnt != 5'd0)
            cnt <= cnt - 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
